// File: rtl/udp_tx_sched_if.sv
// UDP transmit bundle between the frame scheduler and the UDP/MAC stack.
// The scheduler is the master: it requests, streams bytes and states the length.
interface udp_tx_sched_if;
  logic        app_data_request;
  logic        udp_send_ack;
  logic        app_data_in_valid;
  logic [7:0]  app_data_in;
  logic [15:0] app_data_length;

  modport master (
    output app_data_request,
    output app_data_in_valid,
    output app_data_in,
    output app_data_length,
    input  udp_send_ack
  );

  modport slave (
    input  app_data_request,
    input  app_data_in_valid,
    input  app_data_in,
    input  app_data_length,
    output udp_send_ack
  );
endinterface

// File: rtl/udp_tx_sched.sv
// Two-source UDP frame scheduler: resolves ARP, round-robins two byte FIFOs
// into the UDP transmit stream and pulses a per-source completion.
module udp_tx_sched #(
  parameter logic [15:0] PAYLOAD_LEN = 16'd1024,
  parameter logic [15:0] MAX_LEN     = 16'd1472,
  parameter logic [31:0] ARP_TIMEOUT = 32'd125_000_000
) (
  input  logic        rgmii_clk,
  input  logic        rstn,
  input  logic        src0_req,
  input  logic [15:0] src0_len,
  output logic        src0_rd_en,
  input  logic [7:0]  src0_rd_data,
  input  logic        src1_req,
  output logic        src1_rd_en,
  input  logic [7:0]  src1_rd_data,
  output logic        src0_done,
  output logic        src1_done,
  output logic        arp_req,
  input  logic        arp_found,
  input  logic        mac_not_exist,
  input  logic        mac_send_end,
  udp_tx_sched_if.master udp,
  output logic        grant,
  output logic        busy
);

  localparam logic [15:0] SRC1_LEN =
    (PAYLOAD_LEN > MAX_LEN) ? MAX_LEN : PAYLOAD_LEN;

  typedef enum logic [2:0] {
    S_ARP_REQ,
    S_ARP_WAIT,
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_XFER,
    S_SEND_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        r_grant;
  logic        r_resume;
  logic [15:0] r_len;
  logic [15:0] r_rd_cnt;
  logic [31:0] r_arp_cnt;
  logic        r_vld;
  logic [7:0]  r_data;

  logic        w_v0;
  logic        w_v1;
  logic        w_pick;
  logic [15:0] w_len0;
  logic        w_rd;
  logic        w_xfer_end;

  assign w_v0   = src0_req && (src0_len != 16'd0);
  assign w_v1   = src1_req;
  assign w_pick = (w_v0 && w_v1) ? ~r_last : w_v1;
  assign w_len0 = (src0_len > MAX_LEN) ? MAX_LEN : src0_len;
  assign w_rd   = (r_state == S_XFER) && (r_rd_cnt != r_len);

  // The last byte leaves one cycle after its read; a zero length exits at once.
  assign w_xfer_end = (r_rd_cnt == r_len) && (r_vld || (r_len == 16'd0));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_ARP_REQ:   w_next = S_ARP_WAIT;
      S_ARP_WAIT: begin
        if (arp_found)
          w_next = r_resume ? S_CHECK : S_IDLE;
        else if (r_arp_cnt >= ARP_TIMEOUT - 32'd1)
          w_next = S_ARP_REQ;
      end
      S_IDLE:      if (w_v0 || w_v1) w_next = S_CHECK;
      S_CHECK:     w_next = mac_not_exist ? S_ARP_REQ : S_REQ;
      S_REQ:       if (udp.udp_send_ack) w_next = S_XFER;
      S_XFER:      if (w_xfer_end) w_next = S_SEND_WAIT;
      S_SEND_WAIT: if (mac_send_end) w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_ARP_REQ;
    endcase
  end

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) r_state <= S_ARP_REQ;
    else       r_state <= w_next;
  end

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      r_last    <= 1'b1;
      r_grant   <= 1'b0;
      r_resume  <= 1'b0;
      r_len     <= 16'd0;
      r_rd_cnt  <= 16'd0;
      r_arp_cnt <= 32'd0;
      r_vld     <= 1'b0;
      r_data    <= 8'd0;
    end else begin
      r_vld     <= w_rd;
      r_arp_cnt <= (r_state == S_ARP_WAIT) ? r_arp_cnt + 32'd1 : 32'd0;
      r_rd_cnt  <= (r_state == S_XFER) ? r_rd_cnt + {15'd0, w_rd} : 16'd0;
      if (w_rd)
        r_data <= r_grant ? src1_rd_data : src0_rd_data;
      if (r_state == S_IDLE && w_next == S_CHECK) begin
        r_grant <= w_pick;
        r_last  <= w_pick;
        r_len   <= w_pick ? SRC1_LEN : w_len0;
      end
      // A frame interrupted by an unknown MAC re-enters CHECK after ARP.
      if (r_state == S_CHECK && mac_not_exist)
        r_resume <= 1'b1;
      else if (r_state == S_ARP_WAIT && arp_found)
        r_resume <= 1'b0;
    end
  end

  // Reset parks the FSM in ARP_REQ, so state-decoded strobes are gated by rstn.
  assign arp_req = rstn && (r_state == S_ARP_REQ);
  assign busy    = rstn && (r_state != S_IDLE);

  assign src0_rd_en = w_rd && !r_grant;
  assign src1_rd_en = w_rd &&  r_grant;
  assign src0_done  = (r_state == S_DONE) && !r_grant;
  assign src1_done  = (r_state == S_DONE) &&  r_grant;
  assign grant      = r_grant;

  assign udp.app_data_request  = (r_state == S_REQ);
  assign udp.app_data_in_valid = r_vld;
  assign udp.app_data_in       = r_data;
  assign udp.app_data_length   = r_len;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Randomized bench for udp_tx_sched: FIFO and ARP/MAC stubs plus a
// frame-level reference model of arbitration, lengths and byte order.
module tb_udp_tx_sched;

  localparam int T    = 100;
  localparam int MAXL = 1472;
  localparam int PLEN = 1024;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        src0_req = 1'b0;
  logic [15:0] src0_len = 16'd0;
  logic        src0_rd_en;
  logic [7:0]  src0_rd_data;
  logic        src1_req = 1'b0;
  logic        src1_rd_en;
  logic [7:0]  src1_rd_data;
  logic        src0_done;
  logic        src1_done;
  logic        arp_req;
  logic        arp_found = 1'b0;
  logic        mac_not_exist = 1'b0;
  logic        mac_send_end = 1'b0;
  logic        grant;
  logic        busy;

  udp_tx_sched_if u_if ();

  udp_tx_sched #(
    .PAYLOAD_LEN (16'd1024),
    .MAX_LEN     (16'd1472),
    .ARP_TIMEOUT (32'd100)
  ) dut (
    .rgmii_clk     (clk),
    .rstn          (rstn),
    .src0_req      (src0_req),
    .src0_len      (src0_len),
    .src0_rd_en    (src0_rd_en),
    .src0_rd_data  (src0_rd_data),
    .src1_req      (src1_req),
    .src1_rd_en    (src1_rd_en),
    .src1_rd_data  (src1_rd_data),
    .src0_done     (src0_done),
    .src1_done     (src1_done),
    .arp_req       (arp_req),
    .arp_found     (arp_found),
    .mac_not_exist (mac_not_exist),
    .mac_send_end  (mac_send_end),
    .udp           (u_if.master),
    .grant         (grant),
    .busy          (busy)
  );

  always #4 clk = ~clk;

  // Show-ahead FIFO stubs: head byte on rd_data, popped by rd_en.
  logic [7:0]  mem0 [4096];
  logic [7:0]  mem1 [4096];
  logic [11:0] p0 = 12'd0;
  logic [11:0] p1 = 12'd0;
  assign src0_rd_data = mem0[p0];
  assign src1_rd_data = mem1[p1];
  always @(posedge clk) begin
    if (src0_rd_en) p0 <= p0 + 12'd1;
    if (src1_rd_en) p1 <= p1 + 12'd1;
  end

  logic [32:0] outs;
  assign outs = {arp_req, busy, grant, src0_rd_en, src1_rd_en,
                 src0_done, src1_done, u_if.app_data_request,
                 u_if.app_data_in_valid, u_if.app_data_in,
                 u_if.app_data_length};

  int n_chk = 0;
  int n_err = 0;
  int arp_n = 0;
  int arp_wide = 0;
  int d0_n = 0;
  int d1_n = 0;
  int both_n = 0;
  int busy_n = 0;
  int idle_n = 0;
  logic prev_arp = 1'b0;
  int m_last = 1;

  always @(negedge clk) begin
    if (arp_req) arp_n++;
    if (arp_req && prev_arp) arp_wide++;
    prev_arp = arp_req;
    if (src0_done) d0_n++;
    if (src1_done) d1_n++;
    if (src0_rd_en && src1_rd_en) both_n++;
    if (busy) busy_n++;
    if (rstn && !busy) idle_n++;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && v1) return 1 - last;
    return v1 ? 1 : 0;
  endfunction

  function automatic int clamp(input int l);
    return (l > MAXL) ? MAXL : l;
  endfunction

  task automatic rst_release();
    @(posedge clk);
    #1 rstn = 1'b1;
    m_last = 1;
    @(negedge clk);
    chk("arp_first", arp_req, 1);
  endtask

  task automatic arp_answer(input int dly);
    int n = 0;
    while (!arp_req && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("arp_seen", arp_req, 1);
    repeat (dly) @(negedge clk);
    arp_found = 1'b1;
    @(negedge clk);
    arp_found = 1'b0;
  endtask

  task automatic run_frame(input int src, input int len,
                           input int ackd, input int drop);
    int n, rd, vl, bad, oth, f_rd, l_rd, f_v, ad, d0s, d1s, s;
    logic [7:0] e;
    n = 0;
    while (!u_if.app_data_request && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", u_if.app_data_request, 1);
    if (!u_if.app_data_request) return;
    chk("grant", grant, src);
    chk("len", u_if.app_data_length, len);
    s = src ? int'(p1) : int'(p0);
    d0s = d0_n;
    d1s = d1_n;
    ad = (ackd < 0) ? int'($urandom_range(0, 4)) : ackd;
    repeat (ad) @(negedge clk);
    chk("req_hold", u_if.app_data_request, 1);
    u_if.udp_send_ack = 1'b1;
    @(negedge clk);
    u_if.udp_send_ack = 1'b0;
    rd = 0; vl = 0; bad = 0; oth = 0;
    f_rd = -1; l_rd = -1; f_v = -1;
    for (int c = 0; c < len + 8; c++) begin
      if (src ? src1_rd_en : src0_rd_en) begin
        if (f_rd < 0) f_rd = c;
        l_rd = c;
        rd++;
      end
      if (src ? src0_rd_en : src1_rd_en) oth++;
      if (u_if.app_data_in_valid) begin
        if (f_v < 0) f_v = c;
        e = src ? mem1[(s + vl) % 4096] : mem0[(s + vl) % 4096];
        if (u_if.app_data_in !== e) bad++;
        vl++;
      end
      @(negedge clk);
    end
    chk("rd_cnt", rd, len);
    chk("rd_start", f_rd, 0);
    chk("rd_consec", l_rd - f_rd + 1, len);
    chk("vld_cnt", vl, len);
    chk("vld_lag", f_v - f_rd, 1);
    chk("data_bad", bad, 0);
    chk("rd_other", oth, 0);
    chk("early_done", (d0_n - d0s) + (d1_n - d1s), 0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    mac_send_end = 1'b1;
    @(negedge clk);
    mac_send_end = 1'b0;
    chk("done", src ? src1_done : src0_done, 1);
    chk("done_other", src ? src0_done : src1_done, 0);
    if (drop[0]) src0_req = 1'b0;
    if (drop[1]) src1_req = 1'b0;
    @(negedge clk);
    chk("done_pulse", src0_done | src1_done, 0);
    chk("idle", busy, 0);
    m_last = src;
  endtask

  initial begin
    int e, l, n, gap, snap, ds;
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = 8'($urandom);
      mem1[i] = 8'($urandom);
    end
    u_if.udp_send_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", outs, 0);

    rst_release();
    arp_answer(10);
    repeat (2) @(negedge clk);
    chk("arp_once", arp_n, 1);
    chk("start_idle", busy, 0);

    src0_len = 16'd16;
    src0_req = 1'b1;
    e = pick(1'b1, 1'b0, m_last);
    run_frame(e, 16, 3, 1);

    for (int i = 0; i < 3; i++) begin
      l = $urandom_range(1, 200);
      src0_len = 16'(l);
      src0_req = 1'b1;
      e = pick(1'b1, 1'b0, m_last);
      run_frame(e, clamp(l), -1, 1);
    end

    l = $urandom_range(1, 64);
    src0_len = 16'(l);
    src0_req = 1'b1;
    src1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = pick(1'b1, 1'b1, m_last);
      run_frame(e, e ? clamp(PLEN) : clamp(l), -1, (i == 3) ? 3 : 0);
    end

    src0_len = 16'd2000;
    src0_req = 1'b1;
    e = pick(1'b1, 1'b0, m_last);
    run_frame(e, clamp(2000), -1, 1);

    src0_len = 16'd0;
    src0_req = 1'b1;
    snap = busy_n;
    ds = d0_n + d1_n;
    repeat (60) @(negedge clk);
    chk("len0_busy", busy_n - snap, 0);
    chk("len0_done", d0_n + d1_n - ds, 0);
    src0_req = 1'b0;

    mac_not_exist = 1'b1;
    src1_req = 1'b1;
    e = pick(1'b0, 1'b1, m_last);
    n = 0;
    while (!arp_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("nx_arp", arp_req, 1);
    chk("nx_grant", grant, e);
    for (int k = 0; k < 2; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!arp_req && gap < 300);
      chk("arp_period", (gap == T) || (gap == T + 1), 1);
    end
    mac_not_exist = 1'b0;
    repeat ($urandom_range(2, 20)) @(negedge clk);
    arp_found = 1'b1;
    snap = idle_n;
    @(negedge clk);
    arp_found = 1'b0;
    n = 0;
    while (!u_if.app_data_request && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("nx_no_idle", idle_n - snap, 0);
    run_frame(e, clamp(PLEN), -1, 2);

    src0_len = 16'd32;
    src0_req = 1'b1;
    ds = d0_n + d1_n;
    n = 0;
    while (!u_if.app_data_request && n < 20) begin
      @(negedge clk);
      n++;
    end
    u_if.udp_send_ack = 1'b1;
    @(negedge clk);
    u_if.udp_send_ack = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (src0_rd_en) n++;
      if (n == 5) break;
      @(negedge clk);
    end
    chk("xfer_5", n, 5);
    #2 rstn = 1'b0;
    #1 chk("rst_async", outs, 0);
    src0_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hold", outs, 0);
    rst_release();
    arp_answer(5);
    repeat (20) @(negedge clk);
    chk("rst_no_done", d0_n + d1_n - ds, 0);
    chk("rst_idle", busy, 0);

    l = $urandom_range(1, 64);
    src0_len = 16'(l);
    src0_req = 1'b1;
    src1_req = 1'b1;
    e = pick(1'b1, 1'b1, m_last);
    run_frame(e, clamp(l), -1, 3);

    chk("rd_both", both_n, 0);
    chk("arp_wide", arp_wide, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
